// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch -- instruction fetch unit with a single outstanding memory read
//
// It issues word-aligned reads at the current PC. Each returned instruction
// goes to the registered I_* outputs. If downstream is stalling when the data
// arrives, the word is parked in a one-entry buffer. A branch redirect
// squashes everything in flight. If a read was already accepted when the
// redirect came in, its data is discarded when it arrives.
//
// Ports
//   CLK           clock, rising edge
//   RST           synchronous active-high reset
//   STALL         downstream not accepting; I_* hold
//   BRANCH_EN     redirect request (highest priority)
//   BRANCH_PC     redirect target (low two bits ignored)
//   MEM_RD_EN     read request
//   MEM_RD_ADDR   read address (word aligned)
//   MEM_RD_READY  memory accepts the request this cycle
//   MEM_RD_VALID  read data valid (one-cycle pulse)
//   MEM_RD_DATA   instruction word
//   I_PC          PC of delivered instruction
//   I_INST        delivered instruction
//   I_VALID       I_PC / I_INST valid
// -----------------------------------------------------------------------------
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        STALL,
   input  logic        BRANCH_EN,
   input  logic [31:0] BRANCH_PC,
   output logic        MEM_RD_EN,
   output logic [31:0] MEM_RD_ADDR,
   input  logic        MEM_RD_READY,
   input  logic        MEM_RD_VALID,
   input  logic [31:0] MEM_RD_DATA,
   output logic [31:0] I_PC,
   output logic [31:0] I_INST,
   output logic        I_VALID
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_reg,    state_next;
   logic [31:0] pc_reg,       pc_next;
   logic        discard_reg,  discard_next;
   // The buffer is full exactly when the FSM is in ST_HOLD, so it needs no
   // separate valid flag.
   logic [31:0] buf_pc_reg,   buf_pc_next;
   logic [31:0] buf_inst_reg, buf_inst_next;
   logic [31:0] i_pc_reg,     i_pc_next;
   logic [31:0] i_inst_reg,   i_inst_next;
   logic        i_valid_reg,  i_valid_next;

   // Redirect targets are forced to word alignment; the low bits are unused.
   logic branch_pc_unused;
   assign branch_pc_unused = ^BRANCH_PC[1:0];

   assign MEM_RD_EN   = (state_reg == ST_REQ) && !RST;
   assign MEM_RD_ADDR = pc_reg;
   assign I_PC        = i_pc_reg;
   assign I_INST      = i_inst_reg;
   assign I_VALID     = i_valid_reg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= ST_REQ;
         pc_reg       <= RESET_PC;
         discard_reg  <= 1'b0;
         buf_pc_reg   <= 32'h0;
         buf_inst_reg <= 32'h0;
         i_pc_reg     <= 32'h0;
         i_inst_reg   <= 32'h0;
         i_valid_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         discard_reg  <= discard_next;
         buf_pc_reg   <= buf_pc_next;
         buf_inst_reg <= buf_inst_next;
         i_pc_reg     <= i_pc_next;
         i_inst_reg   <= i_inst_next;
         i_valid_reg  <= i_valid_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      discard_next  = discard_reg;
      buf_pc_next   = buf_pc_reg;
      buf_inst_next = buf_inst_reg;
      i_pc_next     = i_pc_reg;
      i_inst_next   = i_inst_reg;
      i_valid_next  = i_valid_reg;

      // With downstream accepting, I_VALID drops unless something is
      // delivered below. Under STALL every I_* output simply holds.
      if (!STALL) begin
         i_valid_next = 1'b0;
      end

      if (BRANCH_EN) begin
         // A redirect overrides stall and every FSM event. The buffer empties
         // because the next state is never ST_HOLD.
         pc_next      = {BRANCH_PC[31:2], 2'b00};
         i_valid_next = 1'b0;
         discard_next = 1'b0;
         state_next   = ST_REQ;
         case (state_reg)
            ST_REQ: begin
               // The old address is accepted on this same edge, so its
               // data is still owed and must be thrown away.
               if (MEM_RD_READY) begin
                  state_next   = ST_WAIT;
                  discard_next = 1'b1;
               end
            end
            ST_WAIT: begin
               // If the data has not arrived yet, keep waiting and drop it
               // when it does. If it arrives now, it is dropped here.
               if (!MEM_RD_VALID) begin
                  state_next   = ST_WAIT;
                  discard_next = 1'b1;
               end
            end
            default: ;
         endcase
      end else begin
         case (state_reg)
            ST_REQ: begin
               if (MEM_RD_READY) begin
                  state_next = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (MEM_RD_VALID) begin
                  if (discard_reg) begin
                     discard_next = 1'b0;
                     state_next   = ST_REQ;
                  end else if (!STALL) begin
                     i_pc_next    = pc_reg;
                     i_inst_next  = MEM_RD_DATA;
                     i_valid_next = 1'b1;
                     pc_next      = pc_reg + 32'd4;
                     state_next   = ST_REQ;
                  end else begin
                     buf_pc_next   = pc_reg;
                     buf_inst_next = MEM_RD_DATA;
                     state_next    = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!STALL) begin
                  i_pc_next    = buf_pc_reg;
                  i_inst_next  = buf_inst_reg;
                  i_valid_next = 1'b1;
                  pc_next      = buf_pc_reg + 32'd4;
                  state_next   = ST_REQ;
               end
            end
            default: begin
               state_next = ST_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fetch -- directed testbench for fetch
//
// Instance dut0 uses the default RESET_PC. Instance dut1 uses 32'hFFFF_FFFC to
// cover PC wrap-around. Both instances share every input. Their handshake
// timing is identical, so the memory model tracks only dut0's requests.
// Memory answers one cycle after an accepted request with inst_of(addr).
// -----------------------------------------------------------------------------
module tb_fetch;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        STALL = 1'b0;
   logic        BRANCH_EN = 1'b0;
   logic [31:0] BRANCH_PC = 32'h0;
   logic        MEM_RD_READY = 1'b0;
   logic        MEM_RD_VALID = 1'b0;
   logic [31:0] MEM_RD_DATA = 32'h0;

   logic        en0, en1, iv0, iv1;
   logic [31:0] addr0, addr1, ipc0, ipc1, iinst0, iinst1;

   int checks = 0;
   int failures = 0;

   logic        acc_flag = 1'b0;
   logic [31:0] acc_addr = 32'h0;

   always #5 CLK = ~CLK;

   fetch #(.RESET_PC(32'h0000_0000)) dut0 (
      .CLK(CLK), .RST(RST), .STALL(STALL), .BRANCH_EN(BRANCH_EN), .BRANCH_PC(BRANCH_PC),
      .MEM_RD_EN(en0), .MEM_RD_ADDR(addr0), .MEM_RD_READY(MEM_RD_READY),
      .MEM_RD_VALID(MEM_RD_VALID), .MEM_RD_DATA(MEM_RD_DATA),
      .I_PC(ipc0), .I_INST(iinst0), .I_VALID(iv0)
   );

   fetch #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
      .CLK(CLK), .RST(RST), .STALL(STALL), .BRANCH_EN(BRANCH_EN), .BRANCH_PC(BRANCH_PC),
      .MEM_RD_EN(en1), .MEM_RD_ADDR(addr1), .MEM_RD_READY(MEM_RD_READY),
      .MEM_RD_VALID(MEM_RD_VALID), .MEM_RD_DATA(MEM_RD_DATA),
      .I_PC(ipc1), .I_INST(iinst1), .I_VALID(iv1)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hC0DE_1234;
   endfunction

   // Runs one clock cycle. Inputs are applied at the falling edge. VALID is
   // returned for a request accepted on the previous rising edge, unless
   // reset is active. When inj is set, VALID is forced with junk data. The
   // task returns 1 time unit after the rising edge, when outputs are sampled.
   task automatic cycle(input logic stall, input logic br, input logic [31:0] bpc,
                        input logic rdy, input logic rst, input logic inj);
      @(negedge CLK);
      STALL        = stall;
      BRANCH_EN    = br;
      BRANCH_PC    = bpc;
      RST          = rst;
      MEM_RD_READY = rdy;
      if (inj) begin
         MEM_RD_VALID = 1'b1;
         MEM_RD_DATA  = 32'hDEAD_BEEF;
      end else begin
         MEM_RD_VALID = acc_flag && !rst;
         MEM_RD_DATA  = inst_of(acc_addr);
      end
      #1;
      acc_flag = en0 && rdy;
      acc_addr = addr0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      cycle(0, 0, 32'h0, 0, 1, 0);
      cycle(0, 0, 32'h0, 0, 1, 0);
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", en0); end
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL rst_ivalid got=%b exp=0", iv0); end
      checks++; if (ipc0 !== 32'h0) begin failures++; $display("FAIL rst_ipc got=%h exp=0", ipc0); end
      checks++; if (iinst0 !== 32'h0) begin failures++; $display("FAIL rst_iinst got=%h exp=0", iinst0); end
      checks++; if (addr0 !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", addr0); end
      checks++; if (addr1 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL rst_addr1 got=%h exp=fffffffc", addr1); end
      $display("reset done");
   endtask

   // Zero-latency stream: deliver PC 0 and PC 4, one instruction every other cycle.
   task automatic test_stream;
      logic [31:0] pc;
      for (int k = 0; k < 2; k++) begin
         pc = 32'(k * 4);
         cycle(0, 0, 32'h0, 1, 0, 0);
         checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL stream_gap_valid pc=%h got=%b exp=0", pc, iv0); end
         checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL stream_wait_en pc=%h got=%b exp=0", pc, en0); end
         cycle(0, 0, 32'h0, 1, 0, 0);
         checks++; if (iv0 !== 1'b1) begin failures++; $display("FAIL stream_valid pc=%h got=%b exp=1", pc, iv0); end
         checks++; if (ipc0 !== pc) begin failures++; $display("FAIL stream_pc got=%h exp=%h", ipc0, pc); end
         checks++; if (iinst0 !== inst_of(pc)) begin failures++; $display("FAIL stream_inst got=%h exp=%h", iinst0, inst_of(pc)); end
         checks++; if (addr0 !== pc + 32'd4) begin failures++; $display("FAIL stream_next_addr got=%h exp=%h", addr0, pc + 32'd4); end
         $display("deliver pc=%h inst=%h", ipc0, iinst0);
         if (k == 0) begin
            // Wrap-around on the RESET_PC=FFFF_FFFC instance.
            checks++; if (ipc1 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_ipc got=%h exp=fffffffc", ipc1); end
            checks++; if (iv1 !== 1'b1) begin failures++; $display("FAIL wrap_ivalid got=%b exp=1", iv1); end
            checks++; if (addr1 !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", addr1); end
            checks++; if (en1 !== 1'b1) begin failures++; $display("FAIL wrap_en got=%b exp=1", en1); end
         end
      end
   endtask

   // Stall while the data for PC 8 returns. The word is parked in HOLD, then released.
   task automatic test_stall;
      cycle(1, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b1) begin failures++; $display("FAIL stall_hold_valid got=%b exp=1", iv0); end
      cycle(1, 0, 32'h0, 1, 0, 0);
      checks++; if (ipc0 !== 32'h4) begin failures++; $display("FAIL stall_hold_pc got=%h exp=4", ipc0); end
      checks++; if (iinst0 !== inst_of(32'h4)) begin failures++; $display("FAIL stall_hold_inst got=%h exp=%h", iinst0, inst_of(32'h4)); end
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL stall_hold_en got=%b exp=0", en0); end
      cycle(1, 0, 32'h0, 1, 0, 0);
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL stall_hold_en2 got=%b exp=0", en0); end
      checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h4) begin failures++; $display("FAIL stall_hold2 got=%b/%h exp=1/00000004", iv0, ipc0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (ipc0 !== 32'h8) begin failures++; $display("FAIL stall_release_pc got=%h exp=8", ipc0); end
      checks++; if (iinst0 !== inst_of(32'h8)) begin failures++; $display("FAIL stall_release_inst got=%h exp=%h", iinst0, inst_of(32'h8)); end
      checks++; if (iv0 !== 1'b1) begin failures++; $display("FAIL stall_release_valid got=%b exp=1", iv0); end
      checks++; if (en0 !== 1'b1 || addr0 !== 32'hC) begin failures++; $display("FAIL stall_next_req got=%b/%h exp=1/0000000c", en0, addr0); end
      $display("deliver pc=%h inst=%h (after stall)", ipc0, iinst0);
   endtask

   // Redirect while in WAIT for PC 16, with the PC 16 data arriving in the same cycle.
   task automatic test_branch_wait;
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (ipc0 !== 32'hC) begin failures++; $display("FAIL br_pre_pc got=%h exp=c", ipc0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(0, 1, 32'h0000_0103, 1, 0, 0);
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL br_drop_valid got=%b exp=0", iv0); end
      checks++; if (en0 !== 1'b1 || addr0 !== 32'h100) begin failures++; $display("FAIL br_new_req got=%b/%h exp=1/00000100", en0, addr0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL br_wait_valid got=%b exp=0", iv0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h100) begin failures++; $display("FAIL br_deliver got=%b/%h exp=1/00000100", iv0, ipc0); end
      checks++; if (iinst0 !== inst_of(32'h100)) begin failures++; $display("FAIL br_inst got=%h exp=%h", iinst0, inst_of(32'h100)); end
      $display("deliver pc=%h inst=%h (after branch)", ipc0, iinst0);
   endtask

   // Redirect in REQ while READY is high and STALL is high. The accepted read
   // is discarded, and the redirect overrides the stall hold.
   task automatic test_branch_discard;
      cycle(1, 1, 32'h0000_0208, 1, 0, 0);
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL disc_valid got=%b exp=0", iv0); end
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL disc_wait_en got=%b exp=0", en0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL disc_drop_valid got=%b exp=0", iv0); end
      checks++; if (en0 !== 1'b1 || addr0 !== 32'h208) begin failures++; $display("FAIL disc_new_req got=%b/%h exp=1/00000208", en0, addr0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h208 || iinst0 !== inst_of(32'h208)) begin
         failures++; $display("FAIL disc_deliver got=%b/%h/%h exp=1/00000208/%h", iv0, ipc0, iinst0, inst_of(32'h208));
      end
      $display("deliver pc=%h inst=%h (after discard)", ipc0, iinst0);
   endtask

   // READY held low for 5 cycles: the request stays stable.
   task automatic test_ready_low;
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 32'h0, 0, 0, 0);
         checks++; if (en0 !== 1'b1 || addr0 !== 32'h20C) begin failures++; $display("FAIL rdylow_req[%0d] got=%b/%h exp=1/0000020c", i, en0, addr0); end
         checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL rdylow_valid[%0d] got=%b exp=0", i, iv0); end
      end
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h20C) begin failures++; $display("FAIL rdylow_deliver got=%b/%h exp=1/0000020c", iv0, ipc0); end
      $display("deliver pc=%h inst=%h (after ready low)", ipc0, iinst0);
   endtask

   // Redirect while holding a buffered word: the buffer must be emptied.
   task automatic test_hold_branch;
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(1, 0, 32'h0, 1, 0, 0);
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL hb_hold_en got=%b exp=0", en0); end
      cycle(1, 1, 32'h0000_0040, 1, 0, 0);
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL hb_valid got=%b exp=0", iv0); end
      checks++; if (en0 !== 1'b1 || addr0 !== 32'h40) begin failures++; $display("FAIL hb_new_req got=%b/%h exp=1/00000040", en0, addr0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h40 || iinst0 !== inst_of(32'h40)) begin
         failures++; $display("FAIL hb_deliver got=%b/%h/%h exp=1/00000040/%h", iv0, ipc0, iinst0, inst_of(32'h40));
      end
      $display("deliver pc=%h inst=%h (after hold redirect)", ipc0, iinst0);
   endtask

   // Reset asserted in WAIT. A stray VALID arrives in the cycle after release.
   task automatic test_reset_mid;
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL rm_wait_en got=%b exp=0", en0); end
      cycle(0, 0, 32'h0, 1, 1, 0);
      checks++; if (en0 !== 1'b0) begin failures++; $display("FAIL rm_rst_en got=%b exp=0", en0); end
      checks++; if (iv0 !== 1'b0 || ipc0 !== 32'h0 || iinst0 !== 32'h0) begin failures++; $display("FAIL rm_rst_out got=%b/%h/%h exp=0/0/0", iv0, ipc0, iinst0); end
      cycle(0, 0, 32'h0, 0, 0, 1);
      checks++; if (iv0 !== 1'b0) begin failures++; $display("FAIL rm_stray_valid got=%b exp=0", iv0); end
      checks++; if (en0 !== 1'b1 || addr0 !== 32'h0) begin failures++; $display("FAIL rm_req got=%b/%h exp=1/00000000", en0, addr0); end
      cycle(0, 0, 32'h0, 1, 0, 0);
      cycle(0, 0, 32'h0, 1, 0, 0);
      checks++; if (iv0 !== 1'b1 || ipc0 !== 32'h0 || iinst0 !== inst_of(32'h0)) begin
         failures++; $display("FAIL rm_first got=%b/%h/%h exp=1/00000000/%h", iv0, ipc0, iinst0, inst_of(32'h0));
      end
      $display("deliver pc=%h inst=%h (after mid reset)", ipc0, iinst0);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch_wait();
      test_branch_discard();
      test_ready_low();
      test_hold_branch();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 STALL  input  1  downstream not accepting; the I_* outputs SHALL hold.
REQ-005 BRANCH_EN  input  1  redirect request from execute.
REQ-006 BRANCH_PC  input  32  redirect target.
REQ-007 MEM_RD_EN  output  1  instruction read request.
REQ-008 MEM_RD_ADDR  output  32  read address (word aligned).
REQ-009 MEM_RD_READY  input  1  memory accepts the request this cycle.
REQ-010 MEM_RD_VALID  input  1  read data valid (1-cycle pulse).
REQ-011 MEM_RD_DATA  input  32  instruction word.
REQ-012 I_PC  output  32  PC of the delivered instruction (registered).
REQ-013 I_INST  output  32  delivered instruction (registered).
REQ-014 I_VALID  output  1  I_PC/I_INST valid (registered).

Function
REQ-015 FSM states: REQ (issue), WAIT (await data), HOLD (1-entry buffer full); at most one outstanding read.
REQ-016 REQ: MEM_RD_EN=1, MEM_RD_ADDR=pc; on MEM_RD_READY=1 -> WAIT; otherwise stay in REQ with the address stable.
REQ-017 WAIT: MEM_RD_EN=0; on MEM_RD_VALID with STALL=0 -> next edge I_PC=pc, I_INST=MEM_RD_DATA, I_VALID=1, pc+=4, state REQ.
REQ-018 WAIT: on MEM_RD_VALID with STALL=1 -> data and pc SHALL be captured into the buffer; state HOLD; the I_* outputs are unchanged.
REQ-019 HOLD: MEM_RD_EN=0; on STALL=0 -> buffer moves to I_*, I_VALID=1, pc+=4, state REQ.
REQ-020 When STALL=0 and no instruction is delivered in a cycle, I_VALID SHALL be 0 on the next edge.
REQ-021 When STALL=1, I_PC/I_INST/I_VALID SHALL hold their values.
REQ-022 BRANCH_EN=1 SHALL have priority over STALL and all FSM events.
REQ-023 On BRANCH_EN=1, the next edge SHALL set pc={BRANCH_PC[31:2],2'b00}, I_VALID=0, and empty the buffer.
REQ-024 Redirect in REQ without READY -> stay in REQ at the new address; the address change is permitted.
REQ-025 Redirect in REQ with READY in the same cycle -> WAIT with discard=1.
REQ-026 Redirect in WAIT -> discard=1 when data has not yet arrived.
REQ-027 Redirect in WAIT with data arriving in the same cycle -> drop the data and go to REQ.
REQ-028 Redirect in HOLD -> REQ.
REQ-029 WAIT with discard=1: the arriving MEM_RD_VALID data SHALL be dropped, discard cleared, state REQ; it SHALL never reach I_*.
REQ-030 pc increment is modulo 2^32: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
REQ-031 MEM_RD_VALID outside WAIT SHALL be ignored.

Reset
REQ-032 RST=1 -> next edge: pc=RESET_PC, state REQ, discard=0, buffer empty, I_PC=0, I_INST=0, I_VALID=0.
REQ-033 MEM_RD_EN SHALL be 0 while RST=1.
REQ-034 Reset mid-operation SHALL abandon any outstanding read; its later MEM_RD_VALID SHALL be ignored because state REQ ignores it.

Verification
REQ-035 Reset, zero-latency memory (READY=1, VALID one cycle after accept), STALL=0 -> I_PC sequence 0,4,8 with I_VALID=1 every other cycle and I_INST matching memory.
REQ-036 STALL=1 raised while data for PC 8 returns -> I_* hold PC 4; HOLD entered, MEM_RD_EN=0; STALL=0 -> I_PC=8 next edge, fetch of 12 issued.
REQ-037 BRANCH_EN=1, BRANCH_PC=32'h0000_0103 while in WAIT for PC 16 -> PC 16 data dropped; next request addr 32'h0000_0100; I_VALID=0 until PC 0x100 is delivered.
REQ-038 MEM_RD_READY held 0 for 5 cycles -> MEM_RD_EN=1 and MEM_RD_ADDR stable for all 5; no I_VALID.
REQ-039 RESET_PC=32'hFFFF_FFFC -> I_PC=FFFF_FFFC, then next fetch address 32'h0000_0000.
REQ-040 RST=1 asserted in WAIT, VALID arrives 1 cycle after reset release -> data ignored; first delivered I_PC=RESET_PC.
